// File: rtl/serial_pkg.sv
// Shared constants and state encoding for the serial link blocks.
package serial_pkg;

    localparam int DEF_CLKS_PER_BIT = 434;
    localparam int DEF_DATA_BITS    = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = IDLE,
        S_START = START,
        S_DATA  = DATA,
        S_STOP  = STOP
    } tx_state_t;

endpackage

// File: rtl/serial_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and ticks o_bit_end on the last cycle.
module serial_baud_cnt
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic clear,
    output logic o_bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    assign o_bit_end = (count == LAST);

    // Wrapping on o_bit_end makes every bit boundary restart the count at 0.
    always_ff @(posedge i_clk) begin
        if (i_rst || clear || o_bit_end)
            count <= '0;
        else
            count <= count + CW'(1);
    end

endmodule

// File: rtl/serial_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, one stop bit.
module serial_tx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int IW = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    tx_state_t            state, state_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [IW-1:0]        idx, idx_n;
    logic                 tx_n, ready_n, busy_n, done_n;
    logic                 bit_end;

    serial_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .clear     (state == S_IDLE),
        .o_bit_end (bit_end)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            shreg   <= '0;
            idx     <= '0;
            o_tx    <= 1'b1;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            idx     <= idx_n;
            o_tx    <= tx_n;
            o_ready <= ready_n;
            o_busy  <= busy_n;
            o_done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        idx_n   = idx;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_valid && o_ready) begin
                    state_n = S_START;
                    shreg_n = i_data;
                    idx_n   = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_n = S_DATA;
                    idx_n   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_n = shreg >> 1;
                    if (idx == LAST_IDX)
                        state_n = S_STOP;
                    else
                        idx_n = idx + IW'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        case (state_n)
            S_START: tx_n = 1'b0;
            S_DATA:  tx_n = shreg_n[0];
            default: tx_n = 1'b1;
        endcase
        ready_n = (state_n == S_IDLE);
        busy_n  = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_serial_tx.sv
// Directed plus random frames on two configurations, checked cycle by cycle against a line-level model.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_a, valid_b;
    logic [7:0] data_a;
    logic [4:0] data_b;
    logic       ready_a, tx_a, busy_a, done_a;
    logic       ready_b, tx_b, busy_b, done_b;

    int errors = 0;
    int checks = 0;

    serial_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_a), .i_data(data_a),
        .o_ready(ready_a), .o_tx(tx_a), .o_busy(busy_a), .o_done(done_a)
    );

    serial_tx #(.CLKS_PER_BIT(2), .DATA_BITS(5)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_b), .i_data(data_b),
        .o_ready(ready_b), .o_tx(tx_b), .o_busy(busy_b), .o_done(done_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input int sel, input logic v, input logic [8:0] d);
        if (sel == 0) begin
            valid_a = v;
            data_a  = d[7:0];
        end else begin
            valid_b = v;
            data_b  = d[4:0];
        end
    endtask

    task automatic outs(input int sel, output logic tx, output logic rdy,
                        output logic bsy, output logic dn);
        tx  = (sel != 0) ? tx_b    : tx_a;
        rdy = (sel != 0) ? ready_b : ready_a;
        bsy = (sel != 0) ? busy_b  : busy_a;
        dn  = (sel != 0) ? done_b  : done_a;
    endtask

    task automatic expect_idle(input int sel, input int n, input string tag);
        logic tx, rdy, bsy, dn;
        for (int i = 0; i < n; i++) begin
            cyc();
            outs(sel, tx, rdy, bsy, dn);
            chk({tag, ".tx"}, tx, 1'b1);
            chk({tag, ".busy"}, bsy, 1'b0);
            chk({tag, ".ready"}, rdy, 1'b1);
            chk({tag, ".done"}, dn, 1'b0);
        end
    endtask

    // Caller has set valid/data at a negedge with the block idle. Returns at the
    // negedge of the done cycle, or of cycle T+stop_at when stop_at is nonzero.
    task automatic frame(input int sel, input logic [8:0] d, input logic bv,
                         input logic [8:0] bd, input string tag, input int stop_at);
        int   cpb, db, len, bp;
        logic tx, rdy, bsy, dn, e;
        cpb = (sel != 0) ? 2 : 4;
        db  = (sel != 0) ? 5 : 8;
        len = (db + 2) * cpb;
        outs(sel, tx, rdy, bsy, dn);
        chk({tag, ".accept_ready"}, rdy, 1'b1);
        cyc();
        drive(sel, bv, bd);
        for (int c = 1; c <= len + 1; c++) begin
            outs(sel, tx, rdy, bsy, dn);
            if (c <= len) begin
                bp = (c - 1) / cpb;
                if (bp == 0)       e = 1'b0;
                else if (bp <= db) e = d[bp-1];
                else               e = 1'b1;
                chk($sformatf("%s.tx@%0d", tag, c), tx, e);
                chk({tag, ".busy"}, bsy, 1'b1);
                chk({tag, ".ready"}, rdy, 1'b0);
                chk({tag, ".done"}, dn, 1'b0);
            end else begin
                chk({tag, ".end_tx"}, tx, 1'b1);
                chk({tag, ".end_ready"}, rdy, 1'b1);
                chk({tag, ".end_busy"}, bsy, 1'b0);
                chk({tag, ".end_done"}, dn, 1'b1);
            end
            if (c == stop_at || c == len + 1) return;
            cyc();
        end
    endtask

    initial begin
        logic [8:0] d, bd;
        logic       bv, tx, rdy, bsy, dn;

        rst = 1'b1;
        drive(0, 1'b1, 9'h0EE);
        drive(1, 1'b1, 9'h01F);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst.tx", tx_a, 1'b1);
            chk("rst.ready", ready_a, 1'b1);
            chk("rst.busy", busy_a, 1'b0);
            chk("rst.done", done_a, 1'b0);
            chk("rst.b_busy", busy_b, 1'b0);
        end
        drive(1, 1'b0, 9'h0);

        // First edge out of reset accepts immediately.
        rst = 1'b0;
        drive(0, 1'b1, 9'h0A5);
        frame(0, 9'h0A5, 1'b0, 9'h0, "a5", 0);
        drive(0, 1'b0, 9'h0);
        expect_idle(0, 3, "a5_idle");

        // Bytes offered while busy are ignored.
        drive(0, 1'b1, 9'h03C);
        frame(0, 9'h03C, 1'b1, 9'h0FF, "busy", 0);
        drive(0, 1'b0, 9'h0);
        expect_idle(0, 8, "busy_idle");

        // Back-to-back: second start immediately follows the done cycle.
        drive(0, 1'b1, 9'h000);
        frame(0, 9'h000, 1'b1, 9'h000, "b2b0", 0);
        drive(0, 1'b1, 9'h0FF);
        frame(0, 9'h0FF, 1'b1, 9'h0FF, "b2b1", 0);
        drive(0, 1'b0, 9'h0);
        expect_idle(0, 4, "b2b_idle");

        // Reset during data bit 3 (cycles T+17..T+20).
        drive(0, 1'b1, 9'h055);
        frame(0, 9'h055, 1'b0, 9'h0, "mr", 18);
        rst = 1'b1;
        cyc();
        outs(0, tx, rdy, bsy, dn);
        chk("mr.tx", tx, 1'b1);
        chk("mr.busy", bsy, 1'b0);
        chk("mr.ready", rdy, 1'b1);
        chk("mr.done", dn, 1'b0);
        rst = 1'b0;
        expect_idle(0, 12, "mr_idle");
        drive(0, 1'b1, 9'h081);
        frame(0, 9'h081, 1'b0, 9'h0, "mr81", 0);
        drive(0, 1'b0, 9'h0);
        expect_idle(0, 2, "mr81_idle");

        for (int i = 0; i < 6; i++) begin
            d  = 9'($urandom_range(0, 255));
            bd = 9'($urandom_range(0, 255));
            bv = 1'($urandom_range(0, 1));
            drive(0, 1'b1, d);
            frame(0, d, bv, bd, $sformatf("rnd%0d", i), 0);
            drive(0, 1'b0, 9'h0);
            expect_idle(0, 1, "rnd_idle");
        end

        // Narrow configuration: 14-cycle frame, done at T+15.
        drive(1, 1'b1, 9'h013);
        frame(1, 9'h013, 1'b0, 9'h0, "b13", 0);
        drive(1, 1'b0, 9'h0);
        expect_idle(1, 2, "b13_idle");
        for (int i = 0; i < 3; i++) begin
            d = 9'($urandom_range(0, 31));
            drive(1, 1'b1, d);
            frame(1, d, 1'b1, 9'h01F, $sformatf("brnd%0d", i), 0);
            drive(1, 1'b0, 9'h0);
            expect_idle(1, 1, "brnd_idle");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
